// File: rtl/sid_pot_scanner.sv
// sid_pot_scanner: SID paddle (POTX/POTY) measurement.
// A 512-cycle period at the 1 MHz SID rate: 256 cycles discharging the paddle
// capacitors, then 256 cycles counting until each axis crosses threshold.
// Each axis result comes either from a synchronized external comparator or
// from an emulated paddle value, selected once per period.
module sid_pot_scanner #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk32,
    input  logic       reset,
    input  logic       ce_1m,
    input  logic       use_pad,
    input  logic [7:0] pad_x,
    input  logic [7:0] pad_y,
    input  logic       cmp_x,
    input  logic       cmp_y,
    output logic       dump,
    output logic [7:0] pot_x,
    output logic [7:0] pot_y,
    output logic       pot_valid
);

    // The measurement state is simply the top bit of the phase counter.
    typedef enum logic {
        ST_DUMP   = 1'b0,
        ST_CHARGE = 1'b1
    } state_t;

    logic [8:0]             phase_r;
    logic [8:0]             phase_inc_s;
    state_t                 state_s;
    logic                   mode_latched_r;
    logic                   phase_end_r;
    logic [SYNC_STAGES-1:0] sync_x_r;
    logic [SYNC_STAGES-1:0] sync_y_r;
    logic [7:0]             cnt_x_r;
    logic [7:0]             cnt_y_r;
    logic                   fired_x_r;
    logic                   fired_y_r;
    logic                   hit_x_s;
    logic                   hit_y_s;
    logic [7:0]             cnt_x_nxt_s;
    logic [7:0]             cnt_y_nxt_s;
    logic                   fired_x_nxt_s;
    logic                   fired_y_nxt_s;

    // One CHARGE step for an axis: {fired, counter}. A fired axis holds
    // regardless of the comparator, so bounce after threshold is ignored;
    // an unfired axis counts up and sticks at 255 instead of wrapping.
    function automatic logic [8:0] axis_step(input logic       fired,
                                             input logic [7:0] cnt,
                                             input logic       hit);
        logic [8:0] nxt;
        if (fired) begin
            nxt = {1'b1, cnt};
        end else if (hit) begin
            nxt = {1'b1, cnt};
        end else if (cnt == 8'd255) begin
            nxt = {1'b0, cnt};
        end else begin
            nxt = {1'b0, cnt + 8'd1};
        end
        return nxt;
    endfunction

    assign phase_inc_s = phase_r + 9'd1;
    assign state_s     = state_t'(phase_r[8]);

    // Effective comparator per axis and the resulting next axis state.
    always_comb begin
        hit_x_s = 1'b0;
        hit_y_s = 1'b0;
        if (mode_latched_r) begin
            hit_x_s = (cnt_x_r >= pad_x);
            hit_y_s = (cnt_y_r >= pad_y);
        end else begin
            hit_x_s = sync_x_r[SYNC_STAGES-1];
            hit_y_s = sync_y_r[SYNC_STAGES-1];
        end
        {fired_x_nxt_s, cnt_x_nxt_s} = axis_step(fired_x_r, cnt_x_r, hit_x_s);
        {fired_y_nxt_s, cnt_y_nxt_s} = axis_step(fired_y_r, cnt_y_r, hit_y_s);
    end

    // Comparator synchronizers, free-running on clk32 so that the asynchronous
    // comparator is settled by the time the next ce_1m samples it.
    always_ff @(posedge clk32) begin
        if (reset) begin
            sync_x_r <= '0;
            sync_y_r <= '0;
        end else begin
            sync_x_r <= {sync_x_r[SYNC_STAGES-2:0], cmp_x};
            sync_y_r <= {sync_y_r[SYNC_STAGES-2:0], cmp_y};
        end
    end

    // Phase sequencing, per-axis measurement and result publication.
    always_ff @(posedge clk32) begin
        if (reset) begin
            phase_r        <= 9'd0;
            dump           <= 1'b1;
            mode_latched_r <= 1'b0;
            phase_end_r    <= 1'b0;
            cnt_x_r        <= 8'd0;
            cnt_y_r        <= 8'd0;
            fired_x_r      <= 1'b0;
            fired_y_r      <= 1'b0;
            pot_x          <= 8'hFF;
            pot_y          <= 8'hFF;
            pot_valid      <= 1'b0;
        end else begin
            // Results are published one clk32 after the phase-511 step.
            phase_end_r <= ce_1m && (phase_r == 9'd511);
            if (ce_1m) begin
                phase_r <= phase_inc_s;
                dump    <= ~phase_inc_s[8];
                case (state_s)
                    ST_DUMP: begin
                        cnt_x_r   <= 8'd0;
                        cnt_y_r   <= 8'd0;
                        fired_x_r <= 1'b0;
                        fired_y_r <= 1'b0;
                        if (phase_r == 9'd255) begin
                            mode_latched_r <= use_pad;
                        end else begin
                            mode_latched_r <= mode_latched_r;
                        end
                    end
                    ST_CHARGE: begin
                        cnt_x_r   <= cnt_x_nxt_s;
                        cnt_y_r   <= cnt_y_nxt_s;
                        fired_x_r <= fired_x_nxt_s;
                        fired_y_r <= fired_y_nxt_s;
                    end
                    default: begin
                        cnt_x_r   <= 8'd0;
                        cnt_y_r   <= 8'd0;
                        fired_x_r <= 1'b0;
                        fired_y_r <= 1'b0;
                    end
                endcase
            end else begin
                phase_r <= phase_r;
            end
            if (phase_end_r) begin
                pot_x     <= cnt_x_r;
                pot_y     <= cnt_y_r;
                pot_valid <= 1'b1;
            end else begin
                pot_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/sid_pot_scanner.md
Name: sid_pot_scanner

Overview:
- Generates the 8-bit POTX/POTY values that feed the SID register file's pot_x/pot_y inputs, which are read back at $19/$1A.
- Models the 6581/8580 paddle measurement: a 512-cycle period at 1 MHz.
  - 256 cycles discharging the paddle capacitors.
  - 256 cycles counting until each capacitor crosses threshold.
- Takes per-axis results either from external comparator inputs (real paddles or an analog model) or from digital paddle values (emulated mouse/joystick paddles).
- Sits between the paddle/controller front-end and the SID core; shares the SID's 1 MHz clock enable.

Parameters:
- SYNC_STAGES, 2, number of clk32 synchronizer flops on each comparator input (legal values 2..3).

Ports:
- clk32  in  1  system clock, 32 MHz.
- reset  in  1  synchronous, active-high.
- ce_1m  in  1  one-clk32 pulse per 1 MHz SID cycle; all scanning advances only on this pulse.
- use_pad  in  1  1 = emulated paddle values, 0 = external comparators.
- pad_x  in  8  emulated X paddle value.
- pad_y  in  8  emulated Y paddle value.
- cmp_x  in  1  async external comparator, X axis; 1 = capacitor above threshold.
- cmp_y  in  1  async external comparator, Y axis.
- dump  out  1  1 = discharge paddle capacitors (drive to the external analog model).
- pot_x  out  8  last completed X measurement.
- pot_y  out  8  last completed Y measurement.
- pot_valid  out  1  one-clk32 pulse when pot_x/pot_y update.

Behaviour:
- Reset (synchronous, active-high; clock clk32):
  - phase=0, state DUMP, dump=1.
  - pot_x=pot_y=8'hFF, pot_valid=0.
  - Axis counters=0, fired flags=0, synchronizer flops=0.
  - Reset mid-period abandons the measurement; outputs return to the reset values and no pot_valid is issued.
- Phase counter:
  - 9-bit, increments on each ce_1m and wraps 511->0.
  - phase[8]=0 is state DUMP; phase[8]=1 is state CHARGE.
  - State is a pure function of the phase counter; there is no separate FSM register beyond it.
- DUMP (phase 0..255):
  - dump=1.
  - Axis counters held at 0, fired flags held at 0.
  - mode_latched <= use_pad on the ce_1m at phase 255, so mode is fixed for the whole CHARGE window.
- CHARGE (phase 256..511): dump=0. For each axis, on every ce_1m:
  - If fired=1: hold.
  - Else if cmp_eff=1: fired<=1, counter holds.
  - Else: counter <= counter+1, saturating at 255 (never wraps to 0).
- Comparator selection (cmp_eff):
  - mode_latched=0: cmp_eff = synchronized cmp_x/cmp_y (last flop of the SYNC_STAGES chain).
  - mode_latched=1: cmp_eff = (counter >= pad), using the current counter value.
  - Consequence: the emulated result equals pad exactly for all pad 0..255.
- End of period, on the ce_1m at phase 511:
  - The axis update for that cycle is applied first.
  - The results then appear on pot_x/pot_y on the next clk32 edge, i.e. pot_x <= final counter value including the phase-511 step.
  - pot_valid=1 for exactly that one clk32 cycle.
- Non-firing axis: if an axis never fires during CHARGE, its counter saturates and the result is 255.
- pot_x/pot_y otherwise hold their values for the full 512 µs; no glitches between updates.
- use_pad or pad changes during CHARGE:
  - A use_pad change does not affect the current measurement; it takes effect next period.
  - A pad_x/pad_y change mid-CHARGE is used as-is from the cycle it changes; no latching required.
- Comparator bounce: after fired=1 a comparator returning low is ignored until the next DUMP.
- Both axes are independent; simultaneous firing is handled in parallel, with no priority.
- Latency: the first valid result appears 512 ce_1m pulses after reset release, plus 1 clk32.
- With ce_1m held low, nothing advances and all outputs hold.

Test Plan:
- Reset, then use_pad=1, pad_x=8'h5A, pad_y=8'h00, run 512 ce_1m -> single pot_valid pulse; pot_x=8'h5A, pot_y=8'h00; dump=1 for phases 0..255 and 0 for phases 256..511.
- Set use_pad=0, tie cmp_x=0 and cmp_y=0 for a full period -> pot_x=pot_y=8'hFF with no counter wrap; then cmp_x rising at CHARGE cycle 100 (async to clk32) -> pot_x in 99..101 depending on the synchronizer, pot_y=8'hFF.
- External mode: cmp_y high at CHARGE cycle 40, back low at cycle 45, high again at cycle 200 -> pot_y equals the first-fire value (about 40); the later edges are ignored.
- Toggle use_pad from 0 to 1 at CHARGE cycle 128 with pad_x=8'h10 -> the current period still reports the external result; the following period reports pot_x=8'h10.
- Assert reset at phase 400 with a valid prior pot_x=8'h33 -> next clk32 pot_x=8'hFF, dump=1, no pot_valid; the next valid result arrives exactly 512 ce_1m pulses after reset release.
- ce_1m stalled for 1000 clk32 cycles mid-CHARGE -> the phase counter, axis counters and outputs are unchanged; the measurement resumes correctly when ce_1m returns.
